mult_fu: RTL and testbench
==========================

Name: mult_fu

Overview:
- Pipelined integer multiply functional unit (RV32M MUL/MULH/MULHSU/MULHU).
- Sits directly upstream of the complete stage and occupies one of its eight FU finish slots.
- Accepts one issued op per cycle, produces a finish flag and a complete packet after a fixed latency.
- Honours per-FU complete-stall backpressure and branch-recovery squash.

Parameters:
- XLEN, 32, operand/result width.
- STAGES, 4, pipeline depth; must divide XLEN; equals issue-to-finish latency.
- PR_W, 6, physical register index width.
- ROB_W, 5, ROB entry index width.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- issue_valid  in  1  op presented this cycle
- issue_func  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- issue_opa  in  XLEN  rs1 value
- issue_opb  in  XLEN  rs2 value
- issue_dest_pr  in  PR_W  destination physical register
- issue_rob_entry  in  ROB_W  ROB index
- issue_halt  in  1  halt marker carried through
- complete_stall  in  1  this FU's bit of the complete stage's fu_c_stall
- squash  in  1  precise-state recovery; flush all in-flight ops
- busy  out  1  FU cannot accept issue this cycle
- fu_finish  out  1  result valid at output this cycle
- c_valid  out  1  same as fu_finish
- c_dest_pr  out  PR_W  destination PR; 0 when not finishing
- c_dest_value  out  XLEN  result; 0 when not finishing
- c_rob_entry  out  ROB_W  ROB index; 0 when not finishing
- c_halt  out  1  carried halt; 0 when not finishing
- c_if_take_branch  out  1  constant 0
- c_target_pc  out  XLEN  constant 0

Behaviour:
- Reset: all stage valid bits cleared.
  - busy=0, fu_finish=0, all c_* outputs 0 from the cycle after reset is sampled.
- Issue acceptance: op accepted when issue_valid & ~busy & ~squash; accepted op enters stage 0 at the next clock edge.
- Operand prep at accept:
  - Sign-extend opa to 2*XLEN for MULH/MULHSU, zero-extend otherwise.
  - Sign-extend opb for MULH only, zero-extend otherwise.
  - Product is taken mod 2^(2*XLEN).
- Arithmetic: each stage adds the partial products for XLEN*2/STAGES multiplier bits into a 2*XLEN accumulator, shifting multiplicand/multiplier accordingly.
  - Final result: low XLEN bits for MUL, high XLEN bits otherwise.
- Latency: accepted at edge N → fu_finish=1 during the cycle after edge N+STAGES-1, i.e. STAGES cycles after issue_valid was presented.
- Throughput: one op per cycle with no stall.
- Metadata (dest_pr, rob_entry, halt, func) travels with each stage.
- Output stage: outputs are driven combinationally from the last stage register, zero-masked when that stage is invalid.
- Stall: when complete_stall=1 and the last stage is valid, the entire pipeline freezes (no stage advances).
  - Outputs hold identical values; fu_finish stays 1.
  - busy = last-stage valid & complete_stall.
  - complete_stall with the last stage invalid has no effect.
- Issue while busy: ignored; upstream RS must not issue.
- Squash:
  - All valid bits are cleared at the next edge and the op in that cycle's issue is dropped.
  - Squash overrides stall and issue in the same cycle.
  - fu_finish may still be 1 in the squash cycle itself; the complete stage and ROB discard it.
- Reset mid-operation: same effect as squash plus outputs zeroed; reset has priority over squash.
- Bubbles: invalid stages advance normally; the pipeline never compacts bubbles during a stall (full freeze).

Decomposition:
- Shared package (sys_defs):
  - MULT_FUNC enum.
  - FU_COMPLETE_PACKET fields already used by the complete stage.
  - A MULT_STAGE_PACKET struct: valid, func, mcand, mplier, product, dest_pr, rob_entry, halt.
  - XLEN/PR/ROB width constants.
- Sub-module mult_stage: one pipeline stage (partial-product accumulate + register with enable/clear), instantiated STAGES times in a generate loop.

Test Plan:
- Reset then idle: fu_finish=0, busy=0, all c_* outputs 0 for 10 cycles.
- Single MUL, opa=7, opb=6, dest_pr=5, rob=3, issued at cycle 0 → cycle 4: fu_finish=1, value=42, dest_pr=5, rob_entry=3; cycle 5 outputs all 0.
- Signed high parts, issued back-to-back in cycles 0–3:
  - MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000
  - MULHU same operands → 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF
  - MUL 0x80000000 × 2 → 0x00000000
  - Finishes appear on consecutive cycles 4–7.
- Stall: two ops back-to-back, complete_stall=1 for 3 cycles when the first finishes.
  - First op's packet held constant, busy=1 throughout.
  - Second op finishes exactly 1 cycle after the stall drops; no duplicate and no loss.
- Squash with 3 ops in flight plus simultaneous issue_valid: next cycle all valid clear, no fu_finish for the following STAGES cycles.
- Reset asserted while stalled with a valid output: outputs 0 next cycle, and a new op then completes with the normal 4-cycle latency.

Source files
------------

// File: rtl/mult_fu_pkg.sv
// Shared types and widths for the pipelined RV32M multiply unit and the
// complete-stage packet it feeds.
package mult_fu_pkg;

    localparam int XLEN       = 32;
    localparam int STAGES     = 4;
    localparam int PR_W       = 6;
    localparam int ROB_W      = 5;
    localparam int PROD_W     = 2 * XLEN;
    localparam int STAGE_BITS = PROD_W / STAGES;

    typedef enum logic [1:0] {
        MULT_MUL    = 2'b00,
        MULT_MULH   = 2'b01,
        MULT_MULHSU = 2'b10,
        MULT_MULHU  = 2'b11
    } mult_func_e;

    typedef struct packed {
        logic             valid;
        logic [PR_W-1:0]  dest_pr;
        logic [XLEN-1:0]  dest_value;
        logic [ROB_W-1:0] rob_entry;
        logic             halt;
        logic             if_take_branch;
        logic [XLEN-1:0]  target_pc;
    } fu_complete_packet_t;

    typedef struct packed {
        logic              valid;
        mult_func_e        func;
        logic [PROD_W-1:0] mcand;
        logic [PROD_W-1:0] mplier;
        logic [PROD_W-1:0] product;
        logic [PR_W-1:0]   dest_pr;
        logic [ROB_W-1:0]  rob_entry;
        logic              halt;
    } mult_stage_packet_t;

    function automatic logic [PROD_W-1:0] mult_extend(input logic [XLEN-1:0] v, input logic sgn);
        return sgn ? {{XLEN{v[XLEN-1]}}, v} : {{XLEN{1'b0}}, v};
    endfunction

    // MUL returns the low word; every high-part variant returns the upper word.
    function automatic logic [XLEN-1:0] mult_select(input mult_func_e f, input logic [PROD_W-1:0] p);
        return (f == MULT_MUL) ? p[XLEN-1:0] : p[PROD_W-1:XLEN];
    endfunction

endpackage

// File: rtl/mult_fu_if.sv
// Issue/complete port bundle between the reservation station, the multiply
// unit and the complete stage.
interface mult_fu_if;
    import mult_fu_pkg::*;

    logic             issue_valid;
    logic [1:0]       issue_func;
    logic [XLEN-1:0]  issue_opa;
    logic [XLEN-1:0]  issue_opb;
    logic [PR_W-1:0]  issue_dest_pr;
    logic [ROB_W-1:0] issue_rob_entry;
    logic             issue_halt;
    logic             complete_stall;
    logic             squash;

    logic             busy;
    logic             fu_finish;
    logic             c_valid;
    logic [PR_W-1:0]  c_dest_pr;
    logic [XLEN-1:0]  c_dest_value;
    logic [ROB_W-1:0] c_rob_entry;
    logic             c_halt;
    logic             c_if_take_branch;
    logic [XLEN-1:0]  c_target_pc;

    modport master (
        output issue_valid, issue_func, issue_opa, issue_opb, issue_dest_pr,
               issue_rob_entry, issue_halt, complete_stall, squash,
        input  busy, fu_finish, c_valid, c_dest_pr, c_dest_value, c_rob_entry,
               c_halt, c_if_take_branch, c_target_pc
    );

    modport slave (
        input  issue_valid, issue_func, issue_opa, issue_opb, issue_dest_pr,
               issue_rob_entry, issue_halt, complete_stall, squash,
        output busy, fu_finish, c_valid, c_dest_pr, c_dest_value, c_rob_entry,
               c_halt, c_if_take_branch, c_target_pc
    );

endinterface

// File: rtl/mult_fu_stage.sv
// One multiply pipeline stage: folds STAGE_BITS multiplier bits into the
// running product, then registers the packet under enable/clear.
module mult_fu_stage
    import mult_fu_pkg::*;
(
    input  logic               clock,
    input  logic               i_clear,
    input  logic               i_enable,
    input  mult_stage_packet_t i_pkt,
    output mult_stage_packet_t o_pkt
);

    mult_stage_packet_t r_pkt;
    mult_stage_packet_t w_next;
    logic [PROD_W-1:0]  w_partial;

    always_comb begin
        w_partial      = i_pkt.mcand * {{(PROD_W-STAGE_BITS){1'b0}}, i_pkt.mplier[STAGE_BITS-1:0]};
        w_next         = i_pkt;
        w_next.product = i_pkt.product + w_partial;
        w_next.mcand   = i_pkt.mcand << STAGE_BITS;
        w_next.mplier  = i_pkt.mplier >> STAGE_BITS;
    end

    // Only the valid bit needs clearing; payload of an invalid stage is masked downstream.
    always_ff @(posedge clock) begin
        if (i_clear) begin
            r_pkt.valid <= 1'b0;
        end else if (i_enable) begin
            r_pkt <= w_next;
        end
    end

    assign o_pkt = r_pkt;

endmodule

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply functional unit: fixed STAGES-cycle latency,
// full-freeze on complete-stage backpressure, flush on squash or reset.
module mult_fu
    import mult_fu_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    mult_fu_if.slave fu
);

    mult_stage_packet_t  w_issue_pkt;
    mult_stage_packet_t  w_stage_pkt [STAGES];
    mult_stage_packet_t  w_last;
    fu_complete_packet_t w_out;
    mult_func_e          w_func;
    logic                w_busy;
    logic                w_advance;
    logic                w_clear;
    logic                w_accept;
    logic                w_unused_ok;

    assign w_last    = w_stage_pkt[STAGES-1];
    assign w_busy    = w_last.valid & fu.complete_stall;
    assign w_advance = ~w_busy;
    assign w_clear   = reset | fu.squash;
    assign w_accept  = fu.issue_valid & ~w_busy & ~fu.squash;
    assign w_func    = mult_func_e'(fu.issue_func);

    // Operand prep: opa is signed for MULH/MULHSU, opb only for MULH.
    always_comb begin
        w_issue_pkt           = '0;
        w_issue_pkt.valid     = w_accept;
        w_issue_pkt.func      = w_func;
        w_issue_pkt.mcand     = mult_extend(fu.issue_opa, (w_func == MULT_MULH) || (w_func == MULT_MULHSU));
        w_issue_pkt.mplier    = mult_extend(fu.issue_opb, (w_func == MULT_MULH));
        w_issue_pkt.dest_pr   = fu.issue_dest_pr;
        w_issue_pkt.rob_entry = fu.issue_rob_entry;
        w_issue_pkt.halt      = fu.issue_halt;
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            mult_stage_packet_t w_in;
            if (gi == 0) begin : g_head
                assign w_in = w_issue_pkt;
            end else begin : g_body
                assign w_in = w_stage_pkt[gi-1];
            end

            mult_fu_stage u_stage (
                .clock    (clock),
                .i_clear  (w_clear),
                .i_enable (w_advance),
                .i_pkt    (w_in),
                .o_pkt    (w_stage_pkt[gi])
            );
        end
    endgenerate

    always_comb begin
        w_out = '0;
        if (w_last.valid) begin
            w_out.valid      = 1'b1;
            w_out.dest_pr    = w_last.dest_pr;
            w_out.dest_value = mult_select(w_last.func, w_last.product);
            w_out.rob_entry  = w_last.rob_entry;
            w_out.halt       = w_last.halt;
        end
    end

    // Shifted operand copies have no consumer after the final stage.
    assign w_unused_ok = ^{w_last.mcand, w_last.mplier};

    assign fu.busy             = w_busy;
    assign fu.fu_finish        = w_out.valid;
    assign fu.c_valid          = w_out.valid;
    assign fu.c_dest_pr        = w_out.dest_pr;
    assign fu.c_dest_value     = w_out.dest_value;
    assign fu.c_rob_entry      = w_out.rob_entry;
    assign fu.c_halt           = w_out.halt;
    assign fu.c_if_take_branch = w_out.if_take_branch;
    assign fu.c_target_pc      = w_out.target_pc;

endmodule

// File: tb/tb_mult_fu.sv
// Bench for mult_fu: directed scenarios plus randomized traffic, all checked
// against an in-order queue model that ages each accepted op.
module tb_mult_fu;
    import mult_fu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mult_fu_if fu_if ();

    mult_fu dut (
        .clock (clock),
        .reset (reset),
        .fu    (fu_if)
    );

    typedef struct {
        logic [31:0] res;
        logic [5:0]  dest;
        logic [4:0]  rob;
        logic        halt;
        int          age;
    } op_t;

    op_t          pend[$];
    logic [31:0]  fin_vals[$];
    int           fin_cyc[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic drive(input logic v, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] d, input logic [4:0] r, input logic h);
        fu_if.issue_valid     = v;
        fu_if.issue_func      = f;
        fu_if.issue_opa       = a;
        fu_if.issue_opb       = b;
        fu_if.issue_dest_pr   = d;
        fu_if.issue_rob_entry = r;
        fu_if.issue_halt      = h;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 6'd0, 5'd0, 1'b0);
    endtask

    // Check the current cycle's outputs, then advance the model across the coming edge.
    task automatic cycle();
        logic vis, frozen;
        op_t t;
        @(negedge clock);
        vis = (pend.size() > 0) && (pend[0].age == STAGES);
        check_val("fu_finish", fu_if.fu_finish, vis);
        check_val("c_valid", fu_if.c_valid, vis);
        check_val("c_dest_value", fu_if.c_dest_value, vis ? pend[0].res : 32'd0);
        check_val("c_dest_pr", fu_if.c_dest_pr, vis ? pend[0].dest : 6'd0);
        check_val("c_rob_entry", fu_if.c_rob_entry, vis ? pend[0].rob : 5'd0);
        check_val("c_halt", fu_if.c_halt, vis ? pend[0].halt : 1'b0);
        check_val("c_if_take_branch", fu_if.c_if_take_branch, 1'b0);
        check_val("c_target_pc", fu_if.c_target_pc, 32'd0);
        frozen = vis && fu_if.complete_stall;
        check_val("busy", fu_if.busy, frozen);
        if (fu_if.fu_finish) begin
            fin_vals.push_back(fu_if.c_dest_value);
            fin_cyc.push_back(cyc);
        end
        if (reset || fu_if.squash) begin
            pend.delete();
        end else if (!frozen) begin
            if (vis) void'(pend.pop_front());
            for (int i = 0; i < pend.size(); i++) begin
                t = pend[i];
                t.age++;
                pend[i] = t;
            end
            if (fu_if.issue_valid) begin
                t.res  = ref_mul(fu_if.issue_func, fu_if.issue_opa, fu_if.issue_opb);
                t.dest = fu_if.issue_dest_pr;
                t.rob  = fu_if.issue_rob_entry;
                t.halt = fu_if.issue_halt;
                t.age  = 1;
                pend.push_back(t);
            end
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    int c0;

    initial begin
        idle();
        fu_if.complete_stall = 1'b0;
        fu_if.squash         = 1'b0;
        @(posedge clock);
        #1;
        cycle();
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cycle();

        // Single MUL 7*6
        fin_vals.delete(); fin_cyc.delete();
        c0 = cyc;
        drive(1'b1, 2'b00, 32'd7, 32'd6, 6'd5, 5'd3, 1'b0);
        cycle();
        idle();
        for (int i = 0; i < 6; i++) cycle();
        check_val("mul_count", fin_vals.size(), 1);
        if (fin_vals.size() >= 1) begin
            check_val("mul_value", fin_vals[0], 32'd42);
            check_val("mul_latency", fin_cyc[0] - c0, 4);
        end

        // High-part variants back to back
        fin_vals.delete(); fin_cyc.delete();
        c0 = cyc;
        drive(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1, 5'd1, 1'b0); cycle();
        drive(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 5'd2, 1'b0); cycle();
        drive(1'b1, 2'b10, 32'hFFFF_FFFF, 32'd2,         6'd3, 5'd3, 1'b1); cycle();
        drive(1'b1, 2'b00, 32'h8000_0000, 32'd2,         6'd4, 5'd4, 1'b0); cycle();
        idle();
        for (int i = 0; i < 6; i++) cycle();
        check_val("hi_count", fin_vals.size(), 4);
        if (fin_vals.size() >= 4) begin
            check_val("mulh_value", fin_vals[0], 32'h0000_0000);
            check_val("mulhu_value", fin_vals[1], 32'hFFFF_FFFE);
            check_val("mulhsu_value", fin_vals[2], 32'hFFFF_FFFF);
            check_val("mul_ovf_value", fin_vals[3], 32'h0000_0000);
            for (int i = 0; i < 4; i++) check_val("hi_timing", fin_cyc[i] - c0, 4 + i);
        end

        // Stall for three cycles as the first op finishes
        fin_vals.delete(); fin_cyc.delete();
        c0 = cyc;
        drive(1'b1, 2'b00, 32'd3, 32'd5, 6'd10, 5'd10, 1'b0); cycle();
        drive(1'b1, 2'b11, 32'h8000_0000, 32'd4, 6'd11, 5'd11, 1'b0); cycle();
        idle();
        cycle(); cycle();
        fu_if.complete_stall = 1'b1;
        cycle(); cycle(); cycle();
        fu_if.complete_stall = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check_val("stall_count", fin_vals.size(), 5);
        if (fin_vals.size() >= 5) begin
            for (int i = 0; i < 4; i++) check_val("stall_hold", fin_vals[i], 32'd15);
            check_val("stall_second", fin_vals[4], 32'd2);
            check_val("stall_second_cyc", fin_cyc[4] - c0, 8);
        end

        // Squash with three ops in flight and a simultaneous issue
        fin_vals.delete(); fin_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 32'd100 + i, 32'd3, 6'(20 + i), 5'(20 + i), 1'b0);
            cycle();
        end
        drive(1'b1, 2'b00, 32'd9, 32'd9, 6'd30, 5'd30, 1'b0);
        fu_if.squash = 1'b1;
        cycle();
        fu_if.squash = 1'b0;
        idle();
        for (int i = 0; i < STAGES + 1; i++) cycle();
        check_val("squash_count", fin_vals.size(), 0);

        // Reset while stalled with a valid output, then a fresh op
        drive(1'b1, 2'b00, 32'd9, 32'd9, 6'd7, 5'd7, 1'b1); cycle();
        idle();
        cycle(); cycle(); cycle();
        fu_if.complete_stall = 1'b1;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        fu_if.complete_stall = 1'b0;
        fin_vals.delete(); fin_cyc.delete();
        c0 = cyc;
        drive(1'b1, 2'b00, 32'd11, 32'd11, 6'd8, 5'd8, 1'b0); cycle();
        idle();
        for (int i = 0; i < 6; i++) cycle();
        check_val("post_reset_count", fin_vals.size(), 1);
        if (fin_vals.size() >= 1) begin
            check_val("post_reset_value", fin_vals[0], 32'd121);
            check_val("post_reset_latency", fin_cyc[0] - c0, 4);
        end

        // Randomized traffic with stalls, squashes and occasional resets
        for (int i = 0; i < 1500; i++) begin
            reset                = ($urandom_range(0, 199) == 0);
            fu_if.squash         = ($urandom_range(0, 39) == 0);
            fu_if.complete_stall = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                  6'($urandom), 5'($urandom), 1'($urandom));
            cycle();
        end
        reset = 1'b0;
        fu_if.squash = 1'b0;
        fu_if.complete_stall = 1'b0;
        idle();
        for (int i = 0; i < STAGES + 2; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
